// File: rtl/aig_eval_seq.sv
// Sequential and-inverter-graph evaluator: fetches one AND-node descriptor at a time,
// evaluates it into a value vector and reports the selected output node.
module aig_eval_seq #(
  parameter int unsigned VAR_COUNT = 5,
  parameter int unsigned NODE_MAX  = 32,
  parameter int unsigned IDX_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [VAR_COUNT-1:0] x,
  input  logic [IDX_W-1:0] node_cnt,
  input  logic [IDX_W-1:0] out_idx,
  input  logic             out_inv,
  output logic             desc_req,
  output logic [IDX_W-1:0] desc_addr,
  input  logic             desc_ack,
  input  logic [IDX_W-1:0] desc_a,
  input  logic [IDX_W-1:0] desc_b,
  input  logic             desc_a_inv,
  input  logic             desc_b_inv,
  output logic             busy,
  output logic             done,
  output logic             z,
  output logic             err
);

  localparam int unsigned VMax = VAR_COUNT + NODE_MAX;
  localparam int unsigned IW   = IDX_W + 1;

  localparam logic [IDX_W:0]   VarBase  = IW'(VAR_COUNT + 1);
  localparam logic [IDX_W:0]   VarCntW  = IW'(VAR_COUNT);
  localparam logic [IDX_W:0]   NodeMaxW = IW'(NODE_MAX);
  localparam logic [IDX_W-1:0] One      = IDX_W'(1);

  typedef enum logic [1:0] {StIdle, StFetch, StEval, StFin} state_e;

  state_e           state_q;
  logic [VMax:0]    v_q;
  logic [IDX_W-1:0] k_q, n_q, oi_q, a_q, b_q, desc_addr_q;
  logic             oinv_q, oob_q, a_inv_q, b_inv_q;
  logic             desc_req_q, busy_q, done_q, z_q, err_q;

  // Out-of-range indices read as 0; range faults are caught separately.
  function automatic logic rd_bit(input logic [VMax:0] vec, input logic [IDX_W:0] idx);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i <= VMax; i++) begin
      if (idx == IW'(i)) r = vec[i];
    end
    return r;
  endfunction

  logic [IDX_W:0] node_idx;
  logic           fanin_fault, node_val, last_node, out_final;
  logic           cnt_over, oob_in, z_start;

  assign node_idx    = VarBase + {1'b0, k_q};
  assign fanin_fault = ({1'b0, a_q} >= node_idx) || ({1'b0, b_q} >= node_idx);
  assign node_val    = (rd_bit(v_q, {1'b0, a_q}) ^ a_inv_q) & (rd_bit(v_q, {1'b0, b_q}) ^ b_inv_q);
  assign last_node   = (k_q == (n_q - One));
  // Forward the node being written this cycle when it is the selected output.
  assign out_final   = ({1'b0, oi_q} == node_idx) ? node_val : rd_bit(v_q, {1'b0, oi_q});

  assign cnt_over = {1'b0, node_cnt} > NodeMaxW;
  assign oob_in   = {1'b0, out_idx} > (VarCntW + {1'b0, node_cnt});
  assign z_start  = rd_bit({v_q[VMax:VAR_COUNT+1], x, 1'b0}, {1'b0, out_idx}) ^ out_inv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      v_q         <= '0;
      k_q         <= '0;
      n_q         <= '0;
      oi_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      desc_addr_q <= '0;
      oinv_q      <= 1'b0;
      oob_q       <= 1'b0;
      a_inv_q     <= 1'b0;
      b_inv_q     <= 1'b0;
      desc_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      z_q         <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            v_q[VAR_COUNT:1] <= x;
            n_q              <= node_cnt;
            oi_q             <= out_idx;
            oinv_q           <= out_inv;
            oob_q            <= oob_in;
            k_q              <= '0;
            err_q            <= 1'b0;
            busy_q           <= 1'b1;
            if (cnt_over) begin
              err_q   <= 1'b1;
              z_q     <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StFin;
            end else if (node_cnt == '0) begin
              err_q   <= oob_in;
              z_q     <= oob_in ? 1'b0 : z_start;
              done_q  <= 1'b1;
              state_q <= StFin;
            end else begin
              desc_req_q  <= 1'b1;
              desc_addr_q <= '0;
              state_q     <= StFetch;
            end
          end
        end
        StFetch: begin
          if (desc_ack) begin
            a_q        <= desc_a;
            b_q        <= desc_b;
            a_inv_q    <= desc_a_inv;
            b_inv_q    <= desc_b_inv;
            desc_req_q <= 1'b0;
            state_q    <= StEval;
          end
        end
        StEval: begin
          if (fanin_fault) begin
            err_q   <= 1'b1;
            z_q     <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StFin;
          end else begin
            for (int unsigned i = VAR_COUNT + 1; i <= VMax; i++) begin
              if (node_idx == IW'(i)) v_q[i] <= node_val;
            end
            if (last_node) begin
              err_q   <= oob_q;
              z_q     <= oob_q ? 1'b0 : (out_final ^ oinv_q);
              done_q  <= 1'b1;
              state_q <= StFin;
            end else begin
              k_q         <= k_q + One;
              desc_req_q  <= 1'b1;
              desc_addr_q <= k_q + One;
              state_q     <= StFetch;
            end
          end
        end
        StFin: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign desc_req  = desc_req_q;
  assign desc_addr = desc_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign z         = z_q;
  assign err       = err_q;

endmodule

// File: doc/aig_eval_seq.md
AIG_EVAL_SEQ -- requirements
Module: aig_eval_seq

Interface
REQ-001 SHALL have parameter VAR_COUNT, default 5: number of primary inputs, node indices 1..VAR_COUNT.
REQ-002 SHALL have parameter NODE_MAX, default 32: maximum AND nodes per evaluation.
REQ-003 SHALL have parameter IDX_W, default 8: node-index width; IDX_W SHALL be at least clog2(VAR_COUNT+NODE_MAX+1).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  begin evaluation; sampled only in IDLE.
REQ-007 SHALL have port x  in  VAR_COUNT  primary inputs; bit i-1 is node i; latched at start.
REQ-008 SHALL have port node_cnt  in  IDX_W  number of AND nodes N; latched at start.
REQ-009 SHALL have port out_idx  in  IDX_W  output node index; latched at start.
REQ-010 SHALL have port out_inv  in  1  output inversion; latched at start.
REQ-011 SHALL have port desc_req  out  1  node-descriptor fetch request.
REQ-012 SHALL have port desc_addr  out  IDX_W  descriptor number k, 0-based.
REQ-013 SHALL have port desc_ack  in  1  descriptor fields valid this cycle.
REQ-014 SHALL have ports desc_a, desc_b  in  IDX_W  fanin node indices.
REQ-015 SHALL have ports desc_a_inv, desc_b_inv  in  1  fanin inversion flags.
REQ-016 SHALL have port busy  out  1  high outside IDLE.
REQ-017 SHALL have port done  out  1  one-cycle completion pulse.
REQ-018 SHALL have port z  out  1  result; held until the next done.
REQ-019 SHALL have port err  out  1  descriptor or output-index fault; valid with done.

Function
REQ-020 SHALL hold a value vector v[0..VAR_COUNT+NODE_MAX]: v[0] is constant 0, v[1..VAR_COUNT] = latched x, v[VAR_COUNT+1+k] = node k.
REQ-021 SHALL implement states IDLE, FETCH, EVAL, FIN.
REQ-022 SHALL, in IDLE with start=1, latch x, node_cnt, out_idx and out_inv, clear err, set k=0, then go to FETCH if N>0, else to FIN.
REQ-023 SHALL treat node_cnt > NODE_MAX as a fault: go to FIN with err=1.
REQ-024 SHALL, in FETCH, drive desc_req=1 and desc_addr=k, holding both stable until desc_ack; on desc_ack it captures the four descriptor fields and goes to EVAL.
REQ-025 SHALL ignore desc_ack whenever desc_req=0.
REQ-026 SHALL, in EVAL, write v[VAR_COUNT+1+k] = (v[a]^a_inv) & (v[b]^b_inv).
REQ-027 SHALL treat a fanin index >= VAR_COUNT+1+k (forward or self reference) as a fault: no write, err=1, go to FIN.
REQ-028 SHALL, after a fault-free EVAL, go to FIN if k=N-1, else increment k and return to FETCH.
REQ-029 SHALL, in FIN, pulse done=1 for one cycle and return to IDLE; z = v[out_idx]^out_inv if out_idx <= VAR_COUNT+N and err=0, else z=0 with err=1.
REQ-030 SHALL meet this latency with zero-wait ack: start sampled at edge 0, done high in cycle 2N+1; each ack wait cycle adds one.
REQ-031 SHALL ignore start while busy=1.
REQ-032 SHALL hold err at its last value until the next accepted start.

Reset
REQ-033 SHALL, while rst_n=0, immediately force state IDLE, desc_req=0, desc_addr=0, busy=0, done=0, z=0, err=0, k=0 and v cleared.
REQ-034 SHALL abandon an evaluation when reset asserts mid-run; no done is produced for it.

Verification
REQ-035 SHALL cover: N=0, out_idx=0, out_inv=1, start -> done in cycle 1, z=1, err=0, desc_req never high.
REQ-036 SHALL cover: x=5'b00010, N=2, desc0=(a=0 inv, b=2), desc1=(a=1 inv, b=5 inv), out_idx=7, immediate acks -> done in cycle 5, z=1; with x=5'b00001 -> z=0.
REQ-037 SHALL cover: same program with desc_ack delayed 3 cycles on desc0 -> desc_req/desc_addr=0 stable 4 cycles, done in cycle 8, same z.
REQ-038 SHALL cover: desc0 a=6 with VAR_COUNT=5 -> done in cycle 3, err=1, z=0; out_idx=9 with N=2 -> err=1.
REQ-039 SHALL cover: start pulsed during FETCH -> ignored, results unchanged; rst_n low during EVAL -> all outputs reset asynchronously, no done.
